exhaustive_gate_checker: RTL and testbench



---
 rtl/exhaustive_gate_checker_pkg.sv | 29 ++
 rtl/exhaustive_gate_checker_if.sv | 29 ++
 rtl/exhaustive_gate_checker_ref_model.sv | 26 ++
 rtl/exhaustive_gate_checker.sv | 163 ++++++++++++++++
 tb/tb_exhaustive_gate_checker.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/exhaustive_gate_checker_pkg.sv
// Shared encodings and helpers for the exhaustive gate checker: gate modes,
// FSM states and the hold-counter width function.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_NAND = 3'd2,
        MODE_NOR  = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_XNOR = 3'd5
    } gate_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_e;

    // A single-cycle hold still needs a 1-bit counter to keep the vector legal.
    function automatic int hold_w(input int hold_cycles);
        if (hold_cycles <= 1) begin
            return 1;
        end else begin
            return $clog2(hold_cycles);
        end
    endfunction

endpackage

// File: rtl/exhaustive_gate_checker_if.sv
// Control, result and DUT-facing signals of the exhaustive gate checker.
// The checker takes the master side; the board/bench takes the slave side.
interface exhaustive_gate_checker_if #(
    parameter int N_INPUTS = 4,
    parameter int ERR_W    = 8
);
    logic                start;
    logic [2:0]          mode;
    logic [N_INPUTS-1:0] pattern_out;
    logic                dut_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [ERR_W-1:0]    err_count;
    logic                first_err_valid;
    logic [N_INPUTS-1:0] first_err_pattern;

    modport master (
        input  start, mode, dut_out,
        output pattern_out, busy, done, pass, err_count,
               first_err_valid, first_err_pattern
    );

    modport slave (
        output start, mode, dut_out,
        input  pattern_out, busy, done, pass, err_count,
               first_err_valid, first_err_pattern
    );
endinterface

// File: rtl/exhaustive_gate_checker_ref_model.sv
// Combinational golden reference: the selected N-input gate applied to a pattern.
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int N_INPUTS = 4
) (
    input  logic [N_INPUTS-1:0] pattern,
    input  logic [2:0]          mode,
    output logic                expected
);

    // Reserved modes never reach DRIVE, so their output is don't-care.
    always_comb begin
        expected = 1'b0;
        case (mode)
            MODE_AND:  expected = &pattern;
            MODE_OR:   expected = |pattern;
            MODE_NAND: expected = ~&pattern;
            MODE_NOR:  expected = ~|pattern;
            MODE_XOR:  expected = ^pattern;
            MODE_XNOR: expected = ~^pattern;
            default:   expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/exhaustive_gate_checker.sv
// Exhaustive stimulus engine: walks all 2^N input patterns, samples the DUT
// once per pattern and accumulates mismatch statistics against gate_ref_model.
module exhaustive_gate_checker
    import gate_chk_pkg::*;
#(
    parameter int N_INPUTS    = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    exhaustive_gate_checker_if.master  bus
);

    localparam int                  HOLD_W    = hold_w(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    // Extra top bit keeps the terminal compare from aliasing with a wrap to 0.
    localparam logic [N_INPUTS:0]   PAT_LAST  = {1'b0, {N_INPUTS{1'b1}}};
    localparam logic [N_INPUTS:0]   PAT_ONE   = (N_INPUTS+1)'(1);
    localparam logic [ERR_W-1:0]    ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0]    ERR_ONE   = ERR_W'(1);

    chk_state_e          state_r;
    chk_state_e          state_next_s;
    logic [2:0]          mode_r;
    logic [N_INPUTS:0]   pattern_r;
    logic [HOLD_W-1:0]   hold_r;
    logic [ERR_W-1:0]    err_count_r;
    logic                first_err_valid_r;
    logic [N_INPUTS-1:0] first_err_pattern_r;
    logic                busy_r;
    logic                done_r;
    logic                pass_r;
    logic                busy_s;
    logic                done_s;
    logic                pass_s;
    logic                start_ok_s;
    logic                accept_s;
    logic                sample_s;
    logic                last_s;
    logic                expected_s;
    logic                mismatch_s;

    gate_ref_model #(
        .N_INPUTS (N_INPUTS)
    ) u_ref (
        .pattern  (pattern_r[N_INPUTS-1:0]),
        .mode     (mode_r),
        .expected (expected_s)
    );

    assign start_ok_s = bus.start && (bus.mode <= MODE_XNOR);
    assign accept_s   = start_ok_s && (state_r != ST_DRIVE);
    assign sample_s   = (state_r == ST_DRIVE) && (hold_r == HOLD_LAST);
    assign last_s     = (pattern_r == PAT_LAST);
    assign mismatch_s = sample_s && (bus.dut_out != expected_s);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_next_s = ST_DRIVE;
                else            state_next_s = ST_IDLE;
            end
            ST_DRIVE: begin
                if (sample_s && last_s) state_next_s = ST_DONE;
                else                    state_next_s = ST_DRIVE;
            end
            ST_DONE: begin
                if (start_ok_s) state_next_s = ST_DRIVE;
                else            state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode, one cycle ahead so the flags come straight from flops
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        pass_s = 1'b0;
        case (state_next_s)
            ST_DRIVE: busy_s = 1'b1;
            ST_DONE: begin
                done_s = 1'b1;
                pass_s = !(first_err_valid_r || mismatch_s);
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Status flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            pass_r <= pass_s;
        end
    end

    // Pattern/hold counters and mismatch bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r              <= 3'd0;
            pattern_r           <= '0;
            hold_r              <= '0;
            err_count_r         <= '0;
            first_err_valid_r   <= 1'b0;
            first_err_pattern_r <= '0;
        end else if (accept_s) begin
            mode_r              <= bus.mode;
            pattern_r           <= '0;
            hold_r              <= '0;
            err_count_r         <= '0;
            first_err_valid_r   <= 1'b0;
            first_err_pattern_r <= '0;
        end else if (state_r == ST_DRIVE) begin
            if (sample_s) begin
                if (mismatch_s) begin
                    if (err_count_r != ERR_MAX) begin
                        err_count_r <= err_count_r + ERR_ONE;
                    end
                    if (!first_err_valid_r) begin
                        first_err_valid_r   <= 1'b1;
                        first_err_pattern_r <= pattern_r[N_INPUTS-1:0];
                    end
                end
                if (!last_s) begin
                    pattern_r <= pattern_r + PAT_ONE;
                    hold_r    <= '0;
                end
            end else begin
                hold_r <= hold_r + HOLD_W'(1);
            end
        end
    end

    assign bus.pattern_out       = pattern_r[N_INPUTS-1:0];
    assign bus.busy              = busy_r;
    assign bus.done              = done_r;
    assign bus.pass              = pass_r;
    assign bus.err_count         = err_count_r;
    assign bus.first_err_valid   = first_err_valid_r;
    assign bus.first_err_pattern = first_err_pattern_r;

endmodule

// File: tb/tb_exhaustive_gate_checker.sv
// Directed bench: three checker instances (N4/H2/E8, N4/H2/E2, N3/H1/E8)
// against simple behavioural gate DUTs with selectable stuck-at faults.
module tb_exhaustive_gate_checker;
    import gate_chk_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [1:0] sel_a = 2'd0;

    always #5 clk = ~clk;

    exhaustive_gate_checker_if #(.N_INPUTS(4), .ERR_W(8)) if_a ();
    exhaustive_gate_checker_if #(.N_INPUTS(4), .ERR_W(2)) if_b ();
    exhaustive_gate_checker_if #(.N_INPUTS(3), .ERR_W(8)) if_c ();

    // sel_a: 0 correct NOR, 1 stuck-at-1, 2 stuck-at-0
    assign if_a.dut_out = (sel_a == 2'd0) ? ~|if_a.pattern_out : (sel_a == 2'd1);
    assign if_b.dut_out = 1'b1;
    assign if_c.dut_out = ^if_c.pattern_out;

    exhaustive_gate_checker #(.N_INPUTS(4), .HOLD_CYCLES(2), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.master));
    exhaustive_gate_checker #(.N_INPUTS(4), .HOLD_CYCLES(2), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.master));
    exhaustive_gate_checker #(.N_INPUTS(3), .HOLD_CYCLES(1), .ERR_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.master));

    function automatic logic busy_of(input int which);
        case (which)
            0:       return if_a.busy;
            1:       return if_b.busy;
            default: return if_c.busy;
        endcase
    endfunction

    // One-cycle start pulse; returns at the first negedge after the accepting edge
    task automatic pulse_start(input int which, input logic [2:0] m);
        case (which)
            0:       begin if_a.start = 1'b1; if_a.mode = m; end
            1:       begin if_b.start = 1'b1; if_b.mode = m; end
            default: begin if_c.start = 1'b1; if_c.mode = m; end
        endcase
        @(negedge clk);
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if_c.start = 1'b0;
    endtask

    task automatic wait_run(input int which, output int cycles);
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_of(which)) break;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (if_a.pattern_out !== 4'd0) begin n_err++; $display("FAIL rst_pattern: got %0d want 0", if_a.pattern_out); end
        n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", if_a.busy); end
        n_cmp++; if (if_a.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", if_a.done); end
        n_cmp++; if (if_a.pass !== 1'b0) begin n_err++; $display("FAIL rst_pass: got %b want 0", if_a.pass); end
        n_cmp++; if (if_a.err_count !== 8'd0) begin n_err++; $display("FAIL rst_err: got %0d want 0", if_a.err_count); end
        n_cmp++; if (if_a.first_err_valid !== 1'b0) begin n_err++; $display("FAIL rst_fev: got %b want 0", if_a.first_err_valid); end
        n_cmp++; if (if_a.first_err_pattern !== 4'd0) begin n_err++; $display("FAIL rst_fep: got %0d want 0", if_a.first_err_pattern); end
        n_cmp++; if ((if_b.busy | if_c.busy) !== 1'b0) begin n_err++; $display("FAIL rst_busy_bc: got %b%b want 00", if_b.busy, if_c.busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode_reserved();
        pulse_start(0, 3'd6);
        n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL mode6_busy: got %b want 0", if_a.busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({if_a.busy, if_a.done} !== 2'b00) begin n_err++; $display("FAIL mode6_idle: got busy/done %b%b want 00", if_a.busy, if_a.done); end
    endtask

    task automatic test_nor_pass();
        int cycles;
        int bad;
        sel_a = 2'd0;
        pulse_start(0, MODE_NOR);
        cycles = 0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (!if_a.busy) break;
            if (if_a.pattern_out !== 4'(cycles / 2)) bad++;
            cycles++;
            @(negedge clk);
        end
        n_cmp++; if (cycles !== 32) begin n_err++; $display("FAIL nor_busy_len: got %0d want 32", cycles); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL nor_pattern_seq: got %0d bad cycles want 0", bad); end
        n_cmp++; if ({if_a.done, if_a.pass} !== 2'b11) begin n_err++; $display("FAIL nor_done_pass: got %b%b want 11", if_a.done, if_a.pass); end
        n_cmp++; if (if_a.err_count !== 8'd0) begin n_err++; $display("FAIL nor_err: got %0d want 0", if_a.err_count); end
        n_cmp++; if (if_a.first_err_valid !== 1'b0) begin n_err++; $display("FAIL nor_fev: got %b want 0", if_a.first_err_valid); end
    endtask

    task automatic test_stuck_faults();
        int cycles;
        sel_a = 2'd1;
        pulse_start(0, MODE_NOR);
        wait_run(0, cycles);
        n_cmp++; if (cycles !== 32) begin n_err++; $display("FAIL s1_busy_len: got %0d want 32", cycles); end
        n_cmp++; if (if_a.err_count !== 8'd15) begin n_err++; $display("FAIL s1_err: got %0d want 15", if_a.err_count); end
        n_cmp++; if (if_a.first_err_pattern !== 4'b0001) begin n_err++; $display("FAIL s1_fep: got %b want 0001", if_a.first_err_pattern); end
        n_cmp++; if ({if_a.done, if_a.pass, if_a.first_err_valid} !== 3'b101) begin n_err++; $display("FAIL s1_flags: got %b%b%b want 101", if_a.done, if_a.pass, if_a.first_err_valid); end
        sel_a = 2'd2;
        pulse_start(0, MODE_NOR);
        wait_run(0, cycles);
        n_cmp++; if (if_a.err_count !== 8'd1) begin n_err++; $display("FAIL s0_err: got %0d want 1", if_a.err_count); end
        n_cmp++; if (if_a.first_err_pattern !== 4'b0000) begin n_err++; $display("FAIL s0_fep: got %b want 0000", if_a.first_err_pattern); end
        n_cmp++; if ({if_a.done, if_a.pass, if_a.first_err_valid} !== 3'b101) begin n_err++; $display("FAIL s0_flags: got %b%b%b want 101", if_a.done, if_a.pass, if_a.first_err_valid); end
    endtask

    task automatic test_saturate();
        int cycles;
        pulse_start(1, MODE_NOR);
        wait_run(1, cycles);
        n_cmp++; if (if_b.err_count !== 2'd3) begin n_err++; $display("FAIL sat_err: got %0d want 3", if_b.err_count); end
        n_cmp++; if (if_b.first_err_pattern !== 4'b0001) begin n_err++; $display("FAIL sat_fep: got %b want 0001", if_b.first_err_pattern); end
        n_cmp++; if ({if_b.done, if_b.pass, if_b.first_err_valid} !== 3'b101) begin n_err++; $display("FAIL sat_flags: got %b%b%b want 101", if_b.done, if_b.pass, if_b.first_err_valid); end
    endtask

    task automatic test_xor_xnor();
        int cycles;
        pulse_start(2, MODE_XOR);
        wait_run(2, cycles);
        n_cmp++; if (cycles !== 8) begin n_err++; $display("FAIL xor_busy_len: got %0d want 8", cycles); end
        n_cmp++; if ({if_c.done, if_c.pass, if_c.err_count} !== {2'b11, 8'd0}) begin n_err++; $display("FAIL xor_result: got done %b pass %b err %0d want 1 1 0", if_c.done, if_c.pass, if_c.err_count); end
        pulse_start(2, MODE_XNOR);
        n_cmp++; if ({if_c.done, if_c.busy} !== 2'b01) begin n_err++; $display("FAIL restart_flags: got done/busy %b%b want 01", if_c.done, if_c.busy); end
        wait_run(2, cycles);
        n_cmp++; if (cycles !== 8) begin n_err++; $display("FAIL xnor_busy_len: got %0d want 8", cycles); end
        n_cmp++; if (if_c.err_count !== 8'd8) begin n_err++; $display("FAIL xnor_err: got %0d want 8", if_c.err_count); end
        n_cmp++; if (if_c.first_err_pattern !== 3'd0) begin n_err++; $display("FAIL xnor_fep: got %0d want 0", if_c.first_err_pattern); end
        n_cmp++; if ({if_c.done, if_c.pass} !== 2'b10) begin n_err++; $display("FAIL xnor_pass: got %b%b want 10", if_c.done, if_c.pass); end
    endtask

    task automatic test_back_to_back();
        int cycles;
        sel_a = 2'd0;
        pulse_start(0, MODE_NOR);
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (!if_a.busy) break;
            if (cycles == 5) begin if_a.start = 1'b1; if_a.mode = MODE_XOR; end
            else             if_a.start = 1'b0;
            cycles++;
            @(negedge clk);
        end
        if_a.start = 1'b0;
        n_cmp++; if (cycles !== 32) begin n_err++; $display("FAIL midstart_len: got %0d want 32", cycles); end
        n_cmp++; if ({if_a.done, if_a.pass, if_a.err_count} !== {2'b11, 8'd0}) begin n_err++; $display("FAIL midstart_result: got done %b pass %b err %0d want 1 1 0", if_a.done, if_a.pass, if_a.err_count); end
    endtask

    task automatic test_reset_midrun();
        int cycles;
        sel_a = 2'd1;
        pulse_start(0, MODE_NOR);
        repeat (10) @(negedge clk);
        n_cmp++; if (if_a.pattern_out !== 4'd5) begin n_err++; $display("FAIL prerst_pattern: got %0d want 5", if_a.pattern_out); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({if_a.busy, if_a.done, if_a.pass, if_a.first_err_valid} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags: got %b%b%b%b want 0000", if_a.busy, if_a.done, if_a.pass, if_a.first_err_valid); end
        n_cmp++; if ({if_a.pattern_out, if_a.err_count, if_a.first_err_pattern} !== 16'd0) begin n_err++; $display("FAIL midrst_data: got pat %0d err %0d fep %0d want 0 0 0", if_a.pattern_out, if_a.err_count, if_a.first_err_pattern); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL postrst_resume: got busy %b want 0", if_a.busy); end
        sel_a = 2'd0;
        pulse_start(0, MODE_NOR);
        n_cmp++; if (if_a.pattern_out !== 4'd0) begin n_err++; $display("FAIL rerun_first: got %0d want 0", if_a.pattern_out); end
        wait_run(0, cycles);
        n_cmp++; if (cycles !== 32) begin n_err++; $display("FAIL rerun_len: got %0d want 32", cycles); end
        n_cmp++; if ({if_a.done, if_a.pass} !== 2'b11) begin n_err++; $display("FAIL rerun_pass: got %b%b want 11", if_a.done, if_a.pass); end
    endtask

    initial begin
        if_a.start = 1'b0; if_a.mode = 3'd0;
        if_b.start = 1'b0; if_b.mode = 3'd0;
        if_c.start = 1'b0; if_c.mode = 3'd0;
        test_reset();
        test_mode_reserved();
        test_nor_pass();
        test_stuck_faults();
        test_saturate();
        test_xor_xnor();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
